// File: rtl/insn_encoder_pkg.sv
// Shared instruction definitions for the encoder: field widths and bit positions,
// opcode class masks, the immediate class decode, and the pipeline word type.
package insn_encoder_pkg;

  localparam int LEN_INSN      = 32;
  localparam int LEN_OPECODE   = 7;
  localparam int SHIFT_OPECODE = 25;
  localparam int LEN_IMMF      = 1;
  localparam int SHIFT_IMMF    = 24;
  localparam int LEN_REGNO     = 4;
  localparam int SHIFT_RD      = 20;
  localparam int SHIFT_RS      = 16;
  localparam int LEN_CC        = 4;
  localparam int SHIFT_CC      = 12;
  localparam int LEN_IMM       = 12;
  localparam int SHIFT_IMM     = 0;
  localparam int LEN_IMM_EX    = 32;

  // Width of the short unsigned immediate used by the SHORT5 class.
  localparam int SHORT_BITS    = 5;

  // Opcode classes are selected by the upper opcode bits; the low three bits are "don't care".
  localparam logic [LEN_OPECODE-1:0] CLASS_MASK = 7'b111_1000;
  localparam logic [LEN_OPECODE-1:0] SIGNED_A   = 7'b000_0000;
  localparam logic [LEN_OPECODE-1:0] SHORT5     = 7'b000_1000;
  localparam logic [LEN_OPECODE-1:0] SIGNED_B   = 7'b001_1000;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_SIGNED,
    IMM_SHORT5,
    IMM_UNSIGNED
  } imm_class_e;

  // One pipeline entry: the packed instruction and its "immediate not representable" flag.
  typedef struct packed {
    logic [LEN_INSN-1:0] insn;
    logic                err;
  } enc_word_t;

  // Decide how the extended immediate is compressed for a given opcode / immediate flag.
  function automatic imm_class_e imm_class(input logic [LEN_OPECODE-1:0] opecode,
                                           input logic [LEN_IMMF-1:0]    immf);
    imm_class_e cls;
    if (immf == '0)                                  cls = IMM_NONE;
    else if ((opecode & CLASS_MASK) == SIGNED_A)     cls = IMM_SIGNED;
    else if ((opecode & CLASS_MASK) == SIGNED_B)     cls = IMM_SIGNED;
    else if ((opecode & CLASS_MASK) == SHORT5)       cls = IMM_SHORT5;
    else                                             cls = IMM_UNSIGNED;
    return cls;
  endfunction

endpackage

// File: rtl/insn_encoder_if.sv
// Handshake and field bundle between an instruction producer/consumer and the encoder.
// master: drives input fields and out_ready; slave: the encoder.
interface insn_encoder_if;
  import insn_encoder_pkg::*;

  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [LEN_OPECODE-1:0] opecode_i;
  logic [LEN_IMMF-1:0]    immf_i;
  logic [LEN_REGNO-1:0]   rd_i;
  logic [LEN_REGNO-1:0]   rs_i;
  logic [LEN_CC-1:0]      cc_i;
  logic [LEN_IMM_EX-1:0]  imm_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [LEN_INSN-1:0]    insn_o;
  logic                   err_o;

  modport master (
    output in_valid_i, opecode_i, immf_i, rd_i, rs_i, cc_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, insn_o, err_o
  );

  modport slave (
    input  in_valid_i, opecode_i, immf_i, rd_i, rs_i, cc_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, insn_o, err_o
  );

endinterface

// File: rtl/insn_imm_compress.sv
// Combinational immediate compression: squeezes the extended immediate into the
// instruction's immediate field according to the opcode class and flags overflow.
module insn_imm_compress
  import insn_encoder_pkg::*;
(
  input  logic [LEN_OPECODE-1:0] opecode,
  input  logic [LEN_IMMF-1:0]    immf,
  input  logic [LEN_IMM_EX-1:0]  imm_ex,
  output logic [LEN_IMM-1:0]     imm_field,
  output logic                   err
);

  imm_class_e cls;

  assign cls = imm_class(opecode, immf);

  // Select the truncated field and the representability check for this class.
  always_comb begin
    imm_field = '0;
    err       = 1'b0;
    case (cls)
      IMM_NONE: begin
        imm_field = '0;
        err       = 1'b0;
      end
      IMM_SIGNED: begin
        // Representable only if every bit from the field's sign bit upward is a copy of it.
        imm_field = imm_ex[LEN_IMM-1:0];
        err       = ~((&imm_ex[LEN_IMM_EX-1:LEN_IMM-1]) | ~(|imm_ex[LEN_IMM_EX-1:LEN_IMM-1]));
      end
      IMM_SHORT5: begin
        imm_field = {{(LEN_IMM-SHORT_BITS){1'b0}}, imm_ex[SHORT_BITS-1:0]};
        err       = |imm_ex[LEN_IMM_EX-1:SHORT_BITS];
      end
      default: begin
        imm_field = imm_ex[LEN_IMM-1:0];
        err       = |imm_ex[LEN_IMM_EX-1:LEN_IMM];
      end
    endcase
  end

endmodule

// File: rtl/insn_encoder.sv
// Instruction encoder: packs decoded fields into an instruction word and streams it
// through an output register backed by one skid register (valid/ready both sides).
// Optional build macro INSN_ENCODER_ERRCNT_EN adds err_cnt_o, a saturating count of
// emitted words flagged with err_o.
module insn_encoder
  import insn_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  insn_encoder_if.slave bus
`ifdef INSN_ENCODER_ERRCNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);

  logic [LEN_IMM-1:0] imm_field;
  logic               imm_err;
  enc_word_t          enc;

  enc_word_t out_word, out_word_next;
  logic      out_valid, out_valid_next;
  enc_word_t skid_word, skid_word_next;
  logic      skid_valid, skid_valid_next;

  logic in_xfer;
  logic out_xfer;
  logic out_load;

  insn_imm_compress u_imm_compress (
    .opecode   (bus.opecode_i),
    .immf      (bus.immf_i),
    .imm_ex    (bus.imm_i),
    .imm_field (imm_field),
    .err       (imm_err)
  );

  // Place every field at its bit position; uncovered bits stay zero.
  always_comb begin
    enc.insn = '0;
    enc.insn[SHIFT_OPECODE +: LEN_OPECODE] = bus.opecode_i;
    enc.insn[SHIFT_IMMF    +: LEN_IMMF]    = bus.immf_i;
    enc.insn[SHIFT_RD      +: LEN_REGNO]   = bus.rd_i;
    enc.insn[SHIFT_RS      +: LEN_REGNO]   = bus.rs_i;
    enc.insn[SHIFT_CC      +: LEN_CC]      = bus.cc_i;
    enc.insn[SHIFT_IMM     +: LEN_IMM]     = imm_field;
    enc.err  = imm_err;
  end

  // in_ready only depends on the skid register, so there is no path from out_ready.
  assign in_xfer  = bus.in_valid_i & ~skid_valid;
  assign out_xfer = out_valid & bus.out_ready_i;
  assign out_load = ~out_valid | bus.out_ready_i;

  // Next-state for the output/skid pair: the skid always has priority so order is kept.
  always_comb begin
    out_word_next   = out_word;
    out_valid_next  = out_valid;
    skid_word_next  = skid_word;
    skid_valid_next = skid_valid;
    if (out_load) begin
      if (skid_valid) begin
        out_word_next   = skid_word;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (in_xfer) begin
        out_word_next  = enc;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (in_xfer) begin
      skid_word_next  = enc;
      skid_valid_next = 1'b1;
    end
  end

  // Pipeline registers; reset discards everything buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_word   <= '0;
      out_valid  <= 1'b0;
      skid_word  <= '0;
      skid_valid <= 1'b0;
    end else begin
      out_word   <= out_word_next;
      out_valid  <= out_valid_next;
      skid_word  <= skid_word_next;
      skid_valid <= skid_valid_next;
    end
  end

  assign bus.in_ready_o  = ~skid_valid;
  assign bus.out_valid_o = out_valid;
  assign bus.insn_o      = out_word.insn;
  assign bus.err_o       = out_word.err;

`ifdef INSN_ENCODER_ERRCNT_EN
  logic [15:0] err_cnt;

  // Count flagged words as they leave; stick at the maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (out_xfer && out_word.err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt;
`else
  logic unused_out_xfer;
  assign unused_out_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_insn_encoder.sv
// Testbench for insn_encoder: directed cases plus randomized streaming against a
// behavioural model that computes each word from field arithmetic and value ranges.
module tb_insn_encoder;
  import insn_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  insn_encoder_if bus ();

`ifdef INSN_ENCODER_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  insn_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef INSN_ENCODER_ERRCNT_EN
    ,
    .err_cnt_o (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int failures    = 0;
  int exp_err_cnt = 0;
  logic [32:0] exp_q[$];

  // Expected {err, insn}: fields weighted by powers of two, immediate judged by value range.
  function automatic logic [32:0] model(input logic [6:0] op, input logic immf,
                                        input logic [3:0] rd, input logic [3:0] rs,
                                        input logic [3:0] cc, input logic [31:0] imm);
    int unsigned f;
    int unsigned grp;
    int          s;
    bit          e;
    int unsigned w;
    s   = $signed(imm);
    grp = 32'(op) / 8;
    if (!immf) begin
      f = 0; e = 1'b0;
    end else if (grp == 0 || grp == 3) begin
      f = imm % 4096; e = (s < -2048) || (s > 2047);
    end else if (grp == 1) begin
      f = imm % 32;   e = (imm > 31);
    end else begin
      f = imm % 4096; e = (imm > 4095);
    end
    w = 32'(op) * 33554432 + 32'(immf) * 16777216 + 32'(rd) * 1048576
      + 32'(rs) * 65536 + 32'(cc) * 4096 + f;
    return {e, w};
  endfunction

  task automatic set_fields(input logic [6:0] op, input logic immf, input logic [3:0] rd,
                            input logic [3:0] rs, input logic [3:0] cc, input logic [31:0] imm);
    bus.opecode_i = op;
    bus.immf_i    = immf;
    bus.rd_i      = rd;
    bus.rs_i      = rs;
    bus.cc_i      = cc;
    bus.imm_i     = imm;
  endtask

  task automatic rand_fields();
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0:       imm = $urandom;
      1:       imm = $urandom_range(0, 40);
      2:       imm = 32'd0 - $urandom_range(0, 3000);
      default: imm = $urandom_range(0, 5000);
    endcase
    set_fields(7'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
               4'($urandom), imm);
  endtask

  function automatic logic [32:0] model_cur();
    return model(bus.opecode_i, bus.immf_i, bus.rd_i, bus.rs_i, bus.cc_i, bus.imm_i);
  endfunction

  // One clock: called at negedge, reports which handshakes happen at the next posedge.
  task automatic step(input logic vld, input logic rdy, output logic in_x, output logic out_x,
                      output logic [31:0] o_insn, output logic o_err);
    bus.in_valid_i  = vld;
    bus.out_ready_i = rdy;
    #1;
    in_x   = vld & bus.in_ready_o;
    out_x  = bus.out_valid_o & rdy;
    o_insn = bus.insn_o;
    o_err  = bus.err_o;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one word with the consumer ready, capture the output one cycle later, then drain it.
  task automatic send_one(input logic [6:0] op, input logic immf, input logic [3:0] rd,
                          input logic [3:0] rs, input logic [3:0] cc, input logic [31:0] imm,
                          output logic v, output logic [31:0] insn, output logic err);
    logic ix, ox, e;
    logic [31:0] w;
    logic [32:0] m;
    set_fields(op, immf, rd, rs, cc, imm);
    m = model(op, immf, rd, rs, cc, imm);
    step(1'b1, 1'b1, ix, ox, w, e);
    bus.in_valid_i = 1'b0;
    #1;
    v    = bus.out_valid_o;
    insn = bus.insn_o;
    err  = bus.err_o;
    if (v && m[32]) exp_err_cnt++;
    step(1'b0, 1'b1, ix, ox, w, e);
  endtask

  task automatic test_reset();
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    set_fields('0, '0, '0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.insn_o !== 32'h0 || bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b ready=%b insn=%h err=%b, required 0 1 00000000 0",
               bus.out_valid_o, bus.in_ready_o, bus.insn_o, bus.err_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL after_reset: valid=%b ready=%b, required 0 1", bus.out_valid_o, bus.in_ready_o);
    end
`ifdef INSN_ENCODER_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_err_cnt: got %0d required 0", err_cnt);
    end
`endif
    $display("test_reset done");
  endtask

  task automatic test_signed();
    logic v, e;
    logic [31:0] w;
    send_one(7'b000_0011, 1'b1, 4'd3, 4'd5, 4'd0, 32'hFFFF_FFFE, v, w, e);
    checks++;
    if (v !== 1'b1 || w !== 32'h0735_0FFE || e !== 1'b0) begin
      failures++;
      $display("FAIL signed_class: valid=%b insn=%h err=%b, required 1 07350ffe 0", v, w, e);
    end
    $display("test_signed insn=%h err=%b", w, e);
  endtask

  task automatic test_short5();
    logic v, e;
    logic [31:0] w;
    send_one(7'b000_1000, 1'b1, 4'd0, 4'd0, 4'd0, 32'h20, v, w, e);
    checks++;
    if (v !== 1'b1 || w !== 32'h1100_0000 || e !== 1'b1) begin
      failures++;
      $display("FAIL short5_overflow: valid=%b insn=%h err=%b, required 1 11000000 1", v, w, e);
    end
`ifdef INSN_ENCODER_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL short5_err_cnt: got %0d required 1", err_cnt);
    end
`endif
    $display("test_short5 insn=%h err=%b", w, e);
  endtask

  task automatic test_boundary();
    logic v, e;
    logic [31:0] w;
    send_one(7'b010_0000, 1'b1, 4'd0, 4'd0, 4'd0, 32'h800, v, w, e);
    checks++;
    if (v !== 1'b1 || w !== 32'h4100_0800 || e !== 1'b0) begin
      failures++;
      $display("FAIL unsigned_800: valid=%b insn=%h err=%b, required 1 41000800 0", v, w, e);
    end
    $display("test_boundary unsigned insn=%h err=%b", w, e);
    send_one(7'b000_0000, 1'b1, 4'd0, 4'd0, 4'd0, 32'h800, v, w, e);
    checks++;
    if (v !== 1'b1 || w !== 32'h0100_0800 || e !== 1'b1) begin
      failures++;
      $display("FAIL signed_800: valid=%b insn=%h err=%b, required 1 01000800 1", v, w, e);
    end
    $display("test_boundary signed insn=%h err=%b", w, e);
    send_one(7'b001_1101, 1'b1, 4'd1, 4'd2, 4'd3, 32'hFFFF_F800, v, w, e);
    checks++;
    if (v !== 1'b1 || w !== 32'h3B12_3800 || e !== 1'b0) begin
      failures++;
      $display("FAIL signed_b_min: valid=%b insn=%h err=%b, required 1 3b123800 0", v, w, e);
    end
    $display("test_boundary signed_b insn=%h err=%b", w, e);
  endtask

  task automatic test_immf0();
    logic v, e;
    logic [31:0] w;
    logic [32:0] m;
    m = model(7'b010_1010, 1'b0, 4'd7, 4'd9, 4'hA, 32'hDEAD_BEEF);
    send_one(7'b010_1010, 1'b0, 4'd7, 4'd9, 4'hA, 32'hDEAD_BEEF, v, w, e);
    checks++;
    if (v !== 1'b1 || w !== m[31:0] || e !== 1'b0 || w[11:0] !== 12'h000) begin
      failures++;
      $display("FAIL immf0: valid=%b insn=%h err=%b, required 1 %h 0", v, w, e, m[31:0]);
    end
    $display("test_immf0 insn=%h err=%b", w, e);
  endtask

  task automatic test_backpressure();
    logic [32:0] words[4];
    logic [6:0] op[4]; logic immf[4]; logic [3:0] rd[4], rs[4], cc[4]; logic [31:0] imm[4];
    logic ix, ox, e;
    logic [31:0] w;
    logic [32:0] m;
    int idx = 0, popped = 0, first_cyc = -1, last_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      op[i] = bus.opecode_i; immf[i] = bus.immf_i; rd[i] = bus.rd_i;
      rs[i] = bus.rs_i; cc[i] = bus.cc_i; imm[i] = bus.imm_i;
      words[i] = model_cur();
    end
    for (int c = 0; c < 4; c++) begin
      set_fields(op[idx], immf[idx], rd[idx], rs[idx], cc[idx], imm[idx]);
      step(1'b1, 1'b0, ix, ox, w, e);
      if (ix) begin exp_q.push_back(words[idx]); idx++; end
    end
    #1;
    checks++;
    if (idx != 2 || bus.in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall: accepted=%0d in_ready=%b, required 2 0", idx, bus.in_ready_o);
    end
    $display("test_backpressure stalled accepted=%0d in_ready=%b", idx, bus.in_ready_o);
    for (int c = 0; c < 20 && popped < 4; c++) begin
      if (idx < 4) set_fields(op[idx], immf[idx], rd[idx], rs[idx], cc[idx], imm[idx]);
      step(idx < 4, 1'b1, ix, ox, w, e);
      if (ox) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra_word: insn=%h err=%b, required none", w, e);
        end else begin
          m = exp_q.pop_front();
          if (m[32]) exp_err_cnt++;
          if (w !== m[31:0] || e !== m[32]) begin
            failures++;
            $display("FAIL bp_order: insn=%h err=%b, required %h %b", w, e, m[31:0], m[32]);
          end
        end
        $display("test_backpressure out insn=%h err=%b", w, e);
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        popped++;
      end
      if (ix) begin exp_q.push_back(words[idx]); idx++; end
    end
    checks++;
    if (popped != 4 || last_cyc - first_cyc != 3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: popped=%0d span=%0d left=%0d, required 4 3 0",
               popped, last_cyc - first_cyc, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic ix, ox, e, pending = 1'b0;
    logic [31:0] w;
    logic [32:0] m;
    int n_out = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && $urandom_range(0, 9) < 7) begin
        rand_fields();
        pending = 1'b1;
      end
      step(pending, ($urandom_range(0, 9) < 7), ix, ox, w, e);
      if (ox) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra_word: insn=%h err=%b, required none", w, e);
        end else begin
          m = exp_q.pop_front();
          if (m[32]) exp_err_cnt++;
          if (w !== m[31:0] || e !== m[32]) begin
            failures++;
            $display("FAIL rand_word: insn=%h err=%b, required %h %b", w, e, m[31:0], m[32]);
          end
        end
        n_out++;
      end
      if (ix) begin
        exp_q.push_back(model_cur());
        pending = 1'b0;
      end
    end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      step(1'b0, 1'b1, ix, ox, w, e);
      if (ox) begin
        checks++;
        m = exp_q.pop_front();
        if (m[32]) exp_err_cnt++;
        if (w !== m[31:0] || e !== m[32]) begin
          failures++;
          $display("FAIL rand_drain_word: insn=%h err=%b, required %h %b", w, e, m[31:0], m[32]);
        end
        n_out++;
      end
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain: left=%0d valid=%b, required 0 0", exp_q.size(), bus.out_valid_o);
    end
`ifdef INSN_ENCODER_ERRCNT_EN
    checks++;
    if (int'(err_cnt) != exp_err_cnt) begin
      failures++;
      $display("FAIL rand_err_cnt: got %0d required %0d", err_cnt, exp_err_cnt);
    end
`endif
    $display("test_random words=%0d errors=%0d", n_out, exp_err_cnt);
  endtask

  task automatic test_reset_midop();
    logic ix, ox, e, v;
    logic [31:0] w;
    for (int c = 0; c < 2; c++) begin
      rand_fields();
      step(1'b1, 1'b0, ix, ox, w, e);
    end
    bus.in_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL midop_full: valid=%b in_ready=%b, required 1 0", bus.out_valid_o, bus.in_ready_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.insn_o !== 32'h0) begin
      failures++;
      $display("FAIL midop_async_reset: valid=%b in_ready=%b insn=%h, required 0 1 00000000",
               bus.out_valid_o, bus.in_ready_o, bus.insn_o);
    end
    exp_q.delete();
    exp_err_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL midop_no_stale: valid=%b, required 0", bus.out_valid_o);
    end
`ifdef INSN_ENCODER_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL midop_err_cnt: got %0d required 0", err_cnt);
    end
`endif
    send_one(7'b000_0011, 1'b1, 4'd3, 4'd5, 4'd0, 32'hFFFF_FFFE, v, w, e);
    checks++;
    if (v !== 1'b1 || w !== 32'h0735_0FFE || e !== 1'b0) begin
      failures++;
      $display("FAIL midop_first_word: valid=%b insn=%h err=%b, required 1 07350ffe 0", v, w, e);
    end
    $display("test_reset_midop first insn=%h err=%b", w, e);
  endtask

  initial begin
    test_reset();
    test_signed();
    test_short5();
    test_boundary();
    test_immf0();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
